// File: rtl/lsu_mem_ctrl_if.sv
// Pipeline request/response and data memory bus bundle for lsu_mem_ctrl.
// slave: controller view; master: pipeline plus memory model view.
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store controller for the single-port data memory bus.
// LSU_MISALIGN_TRAP_EN: trap misaligned half/word ops instead of aligning them.
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_mem_ctrl_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_nxt;
    logic [CW-1:0] r_cnt;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;

    logic        w_accept;
    logic        w_illegal;
    logic        w_mis;
    logic        w_bad;
    logic        w_tmo;
    logic [3:0]  w_be;
    logic [31:0] w_wd;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ldata;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);
    assign w_tmo    = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    assign w_illegal = bus.req_we
        ? (bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11))
        : ((bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11));

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_mis =
        ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
        ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    assign w_mis = 1'b0;
`endif

    assign w_bad = w_illegal || w_mis;

    // Lane strobes and replicated store data from the incoming request
    always_comb begin
        w_be = 4'b0000;
        w_wd = 32'h0;
        unique case (bus.req_funct3[1:0])
            2'b00: begin
                w_be = 4'b0001 << bus.req_addr[1:0];
                w_wd = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                w_be = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                w_wd = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                w_be = 4'b1111;
                w_wd = bus.req_wdata;
            end
        endcase
        if (!bus.req_we) w_wd = 32'h0;
    end

    always_comb begin
        w_byte = bus.mem_rdata[7:0];
        unique case (r_off)
            2'b00: w_byte = bus.mem_rdata[7:0];
            2'b01: w_byte = bus.mem_rdata[15:8];
            2'b10: w_byte = bus.mem_rdata[23:16];
            default: w_byte = bus.mem_rdata[31:24];
        endcase
        w_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        w_ldata = bus.mem_rdata;
        unique case (r_f3[1:0])
            2'b00: w_ldata = {{24{~r_f3[2] & w_byte[7]}}, w_byte};
            2'b01: w_ldata = {{16{~r_f3[2] & w_half[15]}}, w_half};
            default: w_ldata = bus.mem_rdata;
        endcase
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_nxt = w_bad ? S_RESP : S_REQ;
            end
            S_REQ: begin
                if (bus.mem_gnt) w_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_rvalid || w_tmo) w_nxt = S_RESP;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_f3        <= 3'b000;
            r_off       <= 2'b00;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'h0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we        <= bus.req_we;
                        r_f3        <= bus.req_funct3;
                        r_off       <= bus.req_addr[1:0];
                        r_rsp_err   <= w_bad;
                        r_rsp_rdata <= 32'h0;
                        r_cnt       <= '0;
                        if (!w_bad) begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= bus.req_we;
                            r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wd;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= '0;
                    if (bus.mem_gnt) r_mem_req <= 1'b0;
                end
                S_WAIT: begin
                    if (bus.mem_rvalid) begin
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= r_we ? 32'h0 : w_ldata;
                    end else if (w_tmo) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'h0;
                end
            endcase
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl (TIMEOUT_CYCLES = 4).
// Expected values are hand-computed per vector.
module tb_lsu_mem_ctrl;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    lsu_mem_ctrl_if bus ();

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Issue one op; gd = grant stall cycles, rvd = rvalid delay (-1: never)
    task automatic op(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input int gd, input int rvd, input logic [31:0] rd,
                      input int e_lat, input logic e_err,
                      input logic [31:0] e_rdata, input logic e_req,
                      input logic [31:0] e_addr, input logic [3:0] e_be,
                      input logic [31:0] e_wd);
        int c, gc, wc;
        logic gdone, seen, unstable, done;
        logic [31:0] s_addr, s_wd;
        logic [3:0] s_be;
        logic s_we;
        logic [31:0] r_data;
        logic r_err;
        c = 0; gc = 0; wc = 0;
        gdone = 0; seen = 0; unstable = 0; done = 0;
        s_addr = 0; s_wd = 0; s_be = 0; s_we = 0;
        r_data = 0; r_err = 0;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.mem_rdata  = rd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        while (!done && c < 40) begin
            c++;
            if (bus.rsp_valid) begin
                r_data = bus.rsp_rdata;
                r_err  = bus.rsp_err;
                done   = 1;
            end else begin
                bus.mem_gnt    = 1'b0;
                bus.mem_rvalid = 1'b0;
                if (gdone) begin
                    if (rvd >= 0 && wc == rvd) bus.mem_rvalid = 1'b1;
                    wc++;
                end else if (bus.mem_req) begin
                    if (!seen) begin
                        seen = 1;
                        s_addr = bus.mem_addr; s_be = bus.mem_be;
                        s_wd = bus.mem_wdata; s_we = bus.mem_we;
                    end else if (bus.mem_addr !== s_addr ||
                                 bus.mem_be !== s_be ||
                                 bus.mem_wdata !== s_wd ||
                                 bus.mem_we !== s_we) begin
                        unstable = 1;
                    end
                    if (gc == gd) begin
                        bus.mem_gnt = 1'b1;
                        gdone = 1;
                    end
                    gc++;
                end
                @(posedge clk);
                #1;
            end
        end
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".lat"}, 32'(c), 32'(e_lat));
        check({tag, ".err"}, 32'(r_err), 32'(e_err));
        check({tag, ".rdata"}, r_data, e_rdata);
        check({tag, ".req"}, 32'(seen), 32'(e_req));
        if (e_req) begin
            check({tag, ".addr"}, s_addr, e_addr);
            check({tag, ".be"}, 32'(s_be), 32'(e_be));
            check({tag, ".wdata"}, s_wd, e_wd);
            check({tag, ".we"}, 32'(s_we), 32'(we));
            check({tag, ".stable"}, 32'(unstable), 32'd0);
        end
        @(posedge clk);
        #1;
        check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, ".rspoff"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0;
        bus.req_addr = 0; bus.req_wdata = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.ready", 32'(bus.req_ready), 32'd1);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
        check("rst.rdata", bus.rsp_rdata, 32'd0);
        check("rst.mreq", {30'd0, bus.mem_req, bus.mem_we}, 32'd0);
        check("rst.maddr", bus.mem_addr, 32'd0);
        check("rst.mbe", 32'(bus.mem_be), 32'd0);
        check("rst.mwd", bus.mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        op("sb", 1, 3'b000, 32'h1003, 32'h000000A5, 0, 0, 32'h0,
           3, 0, 32'h0, 1, 32'h1000, 4'b1000, 32'hA5A5A5A5);
        op("lh", 0, 3'b001, 32'h2002, 32'h0, 0, 0, 32'h80011234,
           3, 0, 32'hFFFF8001, 1, 32'h2000, 4'b1100, 32'h0);
        op("lhu", 0, 3'b101, 32'h2002, 32'h0, 0, 0, 32'h80011234,
           3, 0, 32'h00008001, 1, 32'h2000, 4'b1100, 32'h0);
        op("lb", 0, 3'b000, 32'h0001, 32'h0, 5, 0, 32'h00007F00,
           8, 0, 32'h0000007F, 1, 32'h0000, 4'b0010, 32'h0);
        op("lbneg", 0, 3'b000, 32'h0003, 32'h0, 0, 0, 32'h80112233,
           3, 0, 32'hFFFFFF80, 1, 32'h0000, 4'b1000, 32'h0);
        op("lbu", 0, 3'b100, 32'h0003, 32'h0, 0, 0, 32'h80112233,
           3, 0, 32'h00000080, 1, 32'h0000, 4'b1000, 32'h0);
        op("lw", 0, 3'b010, 32'h0020, 32'h0, 1, 2, 32'hDEADBEEF,
           6, 0, 32'hDEADBEEF, 1, 32'h0020, 4'b1111, 32'h0);
        op("sh", 1, 3'b001, 32'h0102, 32'h1234BEEF, 0, 0, 32'h0,
           3, 0, 32'h0, 1, 32'h0100, 4'b1100, 32'hBEEFBEEF);
        op("tmo", 0, 3'b010, 32'h0010, 32'h0, 0, -1, 32'h12345678,
           6, 1, 32'h0, 1, 32'h0010, 4'b1111, 32'h0);

        // Stray acknowledge while idle must not produce a response
        bus.mem_rvalid = 1'b1;
        bus.mem_gnt    = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b0;
        bus.mem_gnt    = 1'b0;
        check("stray.rsp", 32'(bus.rsp_valid), 32'd0);
        check("stray.busy", 32'(bus.busy), 32'd0);

`ifdef LSU_MISALIGN_TRAP_EN
        op("swmis", 1, 3'b010, 32'h0006, 32'h12345678, 0, 0, 32'h0,
           1, 1, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
        op("lhmis", 0, 3'b001, 32'h0011, 32'h0, 0, 0, 32'hFFFFFFFF,
           1, 1, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
`else
        op("swmis", 1, 3'b010, 32'h0006, 32'h12345678, 0, 0, 32'h0,
           3, 0, 32'h0, 1, 32'h0004, 4'b1111, 32'h12345678);
        op("lhmis", 0, 3'b001, 32'h0013, 32'h0, 0, 0, 32'h9ABC1234,
           3, 0, 32'hFFFF9ABC, 1, 32'h0010, 4'b1100, 32'h0);
`endif
        op("ill111", 0, 3'b111, 32'h0040, 32'h0, 0, 0, 32'hFFFFFFFF,
           1, 1, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
        op("ills011", 1, 3'b011, 32'h0040, 32'h55, 0, 0, 32'h0,
           1, 1, 32'h0, 0, 32'h0, 4'b0000, 32'h0);

        // Reset while waiting in REQ: mem_req must drop at once
        bus.req_valid = 1; bus.req_we = 0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h80;
        @(posedge clk);
        #1;
        bus.req_valid = 0;
        check("rreq.mreq", 32'(bus.mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rreq.mreq0", 32'(bus.mem_req), 32'd0);
        check("rreq.busy0", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset while in WAIT
        bus.req_valid = 1;
        @(posedge clk);
        #1;
        bus.req_valid = 0;
        bus.mem_gnt   = 1;
        @(posedge clk);
        #1;
        bus.mem_gnt = 0;
        check("rwait.busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rwait.busy0", 32'(bus.busy), 32'd0);
        check("rwait.mreq0", 32'(bus.mem_req), 32'd0);
        check("rwait.rsp0", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.mem_rvalid = 1;
        @(posedge clk);
        #1;
        bus.mem_rvalid = 0;
        check("rwait.rspx", 32'(bus.rsp_valid), 32'd0);
        check("rwait.ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        check("rwait.rspy", 32'(bus.rsp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store unit controller between the RV32I execute stage and the single-port data memory bus. It accepts one load or store per transaction and builds byte-lane strobes and lane-replicated write data from `funct3`/address. It sequences the memory request/grant/response handshake, then returns sign- or zero-extended load data and a completion pulse. The pipeline stalls on `busy`; this block is the only master of the data memory port.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles waited in WAIT for `mem_rvalid` before aborting with error. Range 1..65535; counter width is `$clog2(TIMEOUT_CYCLES+1)`.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: pipeline presents a memory op.
- `req_ready` out 1: high only in IDLE; a transfer is accepted when `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I load/store funct3.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store source (rs2).
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: valid with `rsp_valid`; illegal funct3, timeout, or misalignment (see Configuration).
- `busy` out 1: state != IDLE.
- `mem_req` out 1: bus request, held until grant.
- `mem_gnt` in 1: bus grant.
- `mem_we` out 1: bus write.
- `mem_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rvalid` in 1: response or write acknowledge.
- `mem_rdata` in 32: read word.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- IDLE: on accept, latch `we`, `funct3`, `addr`, `wdata`.
  - Illegal op goes to RESP with err. Illegal ops are loads with funct3 011/110/111, and stores with funct3 >= 011.
  - Any other op goes to REQ.
- REQ: `mem_req`=1 and all `mem_*` outputs stable. On `mem_gnt`, go to WAIT. There is no timeout in REQ.
- WAIT: counter counts up from 0 each cycle.
  - `mem_rvalid` goes to RESP; the load result is captured from `mem_rdata`.
  - Counter == TIMEOUT_CYCLES-1 without rvalid goes to RESP with err.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE.
- Lanes use offset `o = addr[1:0]`:
  - Byte: `be = 4'b0001 << o`; wdata = `{4{wdata[7:0]}}`; load takes `rdata[8*o+:8]`.
  - Half: `be = addr[1] ? 4'b1100 : 4'b0011`; wdata = `{2{wdata[15:0]}}`; load takes `rdata[16*addr[1]+:16]`.
  - Word: `be = 4'b1111`; wdata and load pass through unmodified.
- Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Loads drive `mem_be` with the access-size mask as well. `mem_wdata` = 0 for loads.
- Stores also wait for `mem_rvalid` as the write acknowledge; `rsp_rdata` = 0.
- Outside REQ/WAIT, `mem_rvalid` and `mem_gnt` are ignored. A late rvalid after a timeout is dropped.

## Timing
- Reset values: `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0, counter=0.
- Best case: accept at cycle 0, `mem_req` at cycle 1, gnt at cycle 1, rvalid at cycle 2. `rsp_valid` is then at cycle 3 and `req_ready` returns at cycle 4. Latency is 3 + grant stalls + response stalls.
- Error without bus access: `rsp_valid` at cycle 1 after accept.
- Timeout: `rsp_valid` fires TIMEOUT_CYCLES+1 cycles after the grant cycle.
- All `mem_*` outputs are registered and driven from the latched request; they never change while `mem_req`=1.
- `rst_n` low in any state: everything forced to reset values asynchronously, `mem_req` drops immediately. The in-flight bus transaction is abandoned and no `rsp_valid` is emitted.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a misaligned op goes from IDLE to RESP with `rsp_err`=1 and no bus access. Misaligned means half with `addr[0]`=1, or word with `addr[1:0]` != 0.
- `LSU_MISALIGN_TRAP_EN` undefined: misaligned ops are silently aligned. Half ignores `addr[0]`; word ignores `addr[1:0]`; no error is raised.

## Test plan
- SB, addr 0x1003, wdata 0x000000A5, gnt and rvalid immediate -> `mem_addr`=0x1000, `be`=1000, `mem_wdata`=0xA5A5A5A5; `rsp_valid` at cycle 3, err 0.
- LH addr 0x2002 with rdata 0x8001_1234 -> `be`=1100, `rsp_rdata`=0xFFFF8001. LHU at the same address -> 0x00008001.
- LB addr 0x0001 with rdata 0x0000_7F00 -> 0x0000007F. Hold `mem_gnt` low 5 cycles -> `mem_*` outputs stable, `rsp_valid` at cycle 8.
- TIMEOUT_CYCLES=4, rvalid never asserted -> `rsp_valid` with `rsp_err`=1 and rdata 0, 5 cycles after gnt. A subsequent stray rvalid in IDLE has no effect.
- SW addr 0x0006:
  - with the macro -> err at cycle 1 and `mem_req` never asserted.
  - without the macro -> `mem_addr`=0x0004, `be`=1111, err 0.
  - Illegal funct3 111 load -> err, no `mem_req`.
- `rst_n` pulsed low during WAIT -> `mem_req`/`busy` go 0 immediately, no `rsp_valid`, `req_ready`=1 after release.
